// File: rtl/tank_pkg.sv
// Shared constants and types for the two-tank bullet subsystem.
package tank_pkg;

  localparam int NUM_TANKS = 2;
  localparam int LIFE_W    = 9;
  localparam int CD_W      = 5;

  typedef logic [5:0] angle_t;
  // Wide enough to index the largest (8-slot) pool.
  typedef logic [2:0] slot_idx_t;

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_FLYING = 1'b1
  } slot_state_t;

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: IDLE/FLYING state, owning tank and remaining lifetime.
module bullet_slot
  import tank_pkg::*;
#(
  parameter int LIFETIME = 300
) (
  input  logic frame_clk,
  input  logic reset_n,
  input  logic alloc,
  input  logic owner_in,
  input  logic hit,
  output logic active,
  output logic owner
);

  slot_state_t       state_r, state_s;
  logic [LIFE_W-1:0] life_r, life_s;
  logic              owner_r, owner_s;

  // Next-state: allocation only lands on an idle slot; hit or expiry retires a flying one.
  always_comb begin
    state_s = state_r;
    life_s  = life_r;
    owner_s = owner_r;
    case (state_r)
      SLOT_IDLE: begin
        if (alloc) begin
          state_s = SLOT_FLYING;
          life_s  = LIFE_W'(LIFETIME - 1);
          owner_s = owner_in;
        end else begin
          state_s = SLOT_IDLE;
        end
      end
      SLOT_FLYING: begin
        if (hit || (life_r == {LIFE_W{1'b0}})) begin
          state_s = SLOT_IDLE;
        end else begin
          life_s = life_r - LIFE_W'(1);
        end
      end
      default: state_s = SLOT_IDLE;
    endcase
  end

  // Slot state registers.
  always_ff @(posedge frame_clk) begin
    if (!reset_n) begin
      state_r <= SLOT_IDLE;
      life_r  <= {LIFE_W{1'b0}};
      owner_r <= 1'b0;
    end else begin
      state_r <= state_s;
      life_r  <= life_s;
      owner_r <= owner_s;
    end
  end

  assign active = (state_r == SLOT_FLYING);
  assign owner  = owner_r;

endmodule

// File: rtl/bullet_arbiter.sv
// Turns tank fire keys into bullet spawns: edge detect, pending, cap/cooldown, round-robin, slot pool.
module bullet_arbiter
  import tank_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int MAX_PER_TANK = 2,
  parameter int COOLDOWN     = 15,
  parameter int LIFETIME     = 300
) (
  input  logic                         frame_clk,
  input  logic                         Reset,
  input  logic [1:0]                   fire_req,
  input  logic [5:0]                   angle0,
  input  logic [5:0]                   angle1,
  input  logic [NUM_SLOTS-1:0]         hit_clear,
  output logic                         spawn_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot,
  output logic                         spawn_owner,
  output logic [5:0]                   spawn_angle,
  output logic [NUM_SLOTS-1:0]         slot_active,
  output logic [NUM_SLOTS-1:0]         slot_owner
);

  localparam int SW = $clog2(NUM_SLOTS);

  logic [NUM_TANKS-1:0]            fire_q_r, pending_r, rise_s, req_s, elig_s, pending_s;
  logic [NUM_TANKS-1:0][CD_W-1:0]  cd_r, cd_s;
  logic [NUM_TANKS-1:0][3:0]       cnt_s;
  logic                            rr_r, rr_s, grant_s, winner_s;
  logic [SW-1:0]                   first_free_s;
  logic [NUM_SLOTS-1:0]            alloc_s;
  angle_t                          angle_s;

  // Eligibility and arbitration all work from registered slot state, so a slot
  // retired this frame is only reusable next frame.
  always_comb begin
    rise_s       = fire_req & ~fire_q_r;
    req_s        = pending_r | rise_s;
    cnt_s        = '0;
    first_free_s = {SW{1'b0}};
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (slot_active[s]) begin
        cnt_s[slot_owner[s]] = cnt_s[slot_owner[s]] + 4'd1;
      end else begin
        first_free_s = SW'(s);
      end
    end
    for (int t = 0; t < NUM_TANKS; t++) begin
      elig_s[t] = req_s[t] && (cd_r[t] == {CD_W{1'b0}}) &&
                  (cnt_s[t] < 4'(MAX_PER_TANK)) && !(&slot_active);
    end
    grant_s = |elig_s;
    case (elig_s)
      2'b01:   winner_s = 1'b0;
      2'b10:   winner_s = 1'b1;
      2'b11:   winner_s = rr_r;
      default: winner_s = 1'b0;
    endcase
    if (elig_s == 2'b11) begin
      rr_s = ~rr_r;
    end else begin
      rr_s = rr_r;
    end
    pending_s = req_s;
    alloc_s   = {NUM_SLOTS{1'b0}};
    if (grant_s) begin
      pending_s[winner_s] = 1'b0;
      alloc_s[first_free_s] = 1'b1;
    end else begin
      pending_s = req_s;
    end
    for (int t = 0; t < NUM_TANKS; t++) begin
      if (grant_s && (winner_s == 1'(t))) begin
        cd_s[t] = CD_W'(COOLDOWN);
      end else if (cd_r[t] != {CD_W{1'b0}}) begin
        cd_s[t] = cd_r[t] - CD_W'(1);
      end else begin
        cd_s[t] = {CD_W{1'b0}};
      end
    end
    angle_s = winner_s ? angle1 : angle0;
  end

  // Arbiter state and registered spawn event.
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      fire_q_r    <= 2'b11;
      pending_r   <= 2'b00;
      cd_r        <= '0;
      rr_r        <= 1'b0;
      spawn_valid <= 1'b0;
      spawn_slot  <= {SW{1'b0}};
      spawn_owner <= 1'b0;
      spawn_angle <= 6'd0;
    end else begin
      fire_q_r    <= fire_req;
      pending_r   <= pending_s;
      cd_r        <= cd_s;
      rr_r        <= rr_s;
      spawn_valid <= grant_s;
      if (grant_s) begin
        spawn_slot  <= first_free_s;
        spawn_owner <= winner_s;
        spawn_angle <= angle_s;
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    bullet_slot #(
      .LIFETIME(LIFETIME)
    ) u_slot (
      .frame_clk(frame_clk),
      .reset_n  (Reset),
      .alloc    (alloc_s[g]),
      .owner_in (winner_s),
      .hit      (hit_clear[g]),
      .active   (slot_active[g]),
      .owner    (slot_owner[g])
    );
  end

endmodule

// File: tb/tb_bullet_arbiter.sv
// Scoreboard bench for bullet_arbiter: reference model predicts spawns and slot masks, plus directed checks.
module tb_bullet_arbiter;

  localparam int NS   = 4;
  localparam int MAXP = 2;
  localparam int COOL = 15;
  localparam int LIFE = 40;

  logic          frame_clk;
  logic          Reset;
  logic [1:0]    fire_req;
  logic [5:0]    angle0, angle1;
  logic [NS-1:0] hit_clear;
  logic          spawn_valid;
  logic [1:0]    spawn_slot;
  logic          spawn_owner;
  logic [5:0]    spawn_angle;
  logic [NS-1:0] slot_active;
  logic [NS-1:0] slot_owner;

  bullet_arbiter #(
    .NUM_SLOTS(NS), .MAX_PER_TANK(MAXP), .COOLDOWN(COOL), .LIFETIME(LIFE)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .fire_req   (fire_req),
    .angle0     (angle0),
    .angle1     (angle1),
    .hit_clear  (hit_clear),
    .spawn_valid(spawn_valid),
    .spawn_slot (spawn_slot),
    .spawn_owner(spawn_owner),
    .spawn_angle(spawn_angle),
    .slot_active(slot_active),
    .slot_owner (slot_owner)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int slot;
    int owner;
    int angle;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  bit       m_active[NS];
  int       m_owner[NS];
  int       m_life[NS];
  int       m_cd[2];
  bit [1:0] m_pend;
  int       m_rr;
  bit [1:0] m_fq;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Predict the effect of the coming clock edge from the inputs now applied.
  task automatic model_edge();
    int       cnt[2];
    int       ff;
    int       win;
    bit [1:0] rise, req, elig;
    if (!Reset) begin
      for (int s = 0; s < NS; s++) begin
        m_active[s] = 1'b0;
        m_owner[s]  = 0;
        m_life[s]   = 0;
      end
      m_cd[0] = 0;
      m_cd[1] = 0;
      m_pend  = 2'b00;
      m_rr    = 0;
      m_fq    = 2'b11;
    end else begin
      rise   = fire_req & ~m_fq;
      req    = m_pend | rise;
      cnt[0] = 0;
      cnt[1] = 0;
      ff     = -1;
      for (int s = 0; s < NS; s++) begin
        if (m_active[s]) cnt[m_owner[s]]++;
        else if (ff < 0) ff = s;
      end
      for (int t = 0; t < 2; t++) elig[t] = req[t] && (m_cd[t] == 0) && (cnt[t] < MAXP) && (ff >= 0);
      win = -1;
      if (elig == 2'b11) begin
        win  = m_rr;
        m_rr = 1 - m_rr;
      end else if (elig[0]) win = 0;
      else if (elig[1]) win = 1;
      for (int s = 0; s < NS; s++) begin
        if (m_active[s]) begin
          if (hit_clear[s] || m_life[s] == 0) m_active[s] = 1'b0;
          else m_life[s]--;
        end
      end
      for (int t = 0; t < 2; t++) if (m_cd[t] > 0) m_cd[t]--;
      m_pend = req;
      if (win >= 0) begin
        m_active[ff] = 1'b1;
        m_owner[ff]  = win;
        m_life[ff]   = LIFE - 1;
        m_cd[win]    = COOL;
        m_pend[win]  = 1'b0;
        sb_q.push_back('{ff, win, (win == 1) ? int'(angle1) : int'(angle0)});
      end
      m_fq = fire_req;
    end
  endtask

  // One frame: model, clock edge, then compare DUT outputs against the scoreboard.
  task automatic step();
    exp_t     e;
    bit [3:0] am, om;
    model_edge();
    @(posedge frame_clk);
    #1;
    chk("sb_valid", spawn_valid, (sb_q.size() != 0) ? 1 : 0);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (spawn_valid) begin
        chk("sb_slot", spawn_slot, e.slot);
        chk("sb_owner", spawn_owner, e.owner);
        chk("sb_angle", spawn_angle, e.angle);
      end
    end
    am = '0;
    om = '0;
    for (int s = 0; s < NS; s++) begin
      am[s] = m_active[s];
      om[s] = m_active[s] && (m_owner[s] == 1);
    end
    chk("sb_active", slot_active, am);
    chk("sb_owner_mask", slot_owner & slot_active, om);
  endtask

  task automatic idle(input int n);
    fire_req  = 2'b00;
    hit_clear = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int spawns;
    Reset     = 1'b0;
    fire_req  = 2'b00;
    angle0    = 6'd0;
    angle1    = 6'd0;
    hit_clear = '0;

    // reset and basic spawn
    step();
    step();
    chk("rst_valid", spawn_valid, 0);
    chk("rst_slot", spawn_slot, 0);
    chk("rst_owner", spawn_owner, 0);
    chk("rst_angle", spawn_angle, 0);
    chk("rst_active", slot_active, 0);
    chk("rst_slot_owner", slot_owner, 0);
    Reset = 1'b1;
    step();
    fire_req = 2'b01;
    angle0   = 6'd17;
    angle1   = 6'd42;
    step();
    chk("basic_valid", spawn_valid, 1);
    chk("basic_slot", spawn_slot, 0);
    chk("basic_owner", spawn_owner, 0);
    chk("basic_angle", spawn_angle, 17);
    spawns = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (spawn_valid) spawns++;
    end
    chk("hold_no_respawn", spawns, 0);
    idle(45);

    // simultaneous presses and round-robin
    fire_req = 2'b11;
    angle0   = 6'd3;
    angle1   = 6'd50;
    step();
    chk("sim1_owner", spawn_owner, 0);
    chk("sim1_slot", spawn_slot, 0);
    step();
    chk("sim2_valid", spawn_valid, 1);
    chk("sim2_owner", spawn_owner, 1);
    chk("sim2_slot", spawn_slot, 1);
    chk("sim2_angle", spawn_angle, 50);
    idle(45);
    fire_req = 2'b11;
    step();
    chk("rr_owner", spawn_owner, 1);
    chk("rr_slot", spawn_slot, 0);
    step();
    chk("rr_next_owner", spawn_owner, 0);
    idle(45);

    // cooldown then cap: presses at 0, 5 and 18
    for (int k = 0; k <= 41; k++) begin
      fire_req = (k == 0 || k == 5 || k == 18) ? 2'b01 : 2'b00;
      step();
      chk("cd_cap_valid", spawn_valid, (k == 0 || k == 16 || k == 41) ? 1 : 0);
      if (k == 16) chk("cd_slot", spawn_slot, 1);
      if (k == 41) chk("cap_slot", spawn_slot, 0);
    end
    idle(45);

    // lifetime: exactly LIFE frames active, then slot 0 reused
    fire_req = 2'b01;
    step();
    chk("life_spawn", spawn_valid, 1);
    fire_req = 2'b00;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("life_active0", slot_active[0], (k <= 39) ? 1 : 0);
    end
    fire_req = 2'b01;
    step();
    chk("life_respawn", spawn_valid, 1);
    chk("life_respawn_slot", spawn_slot, 0);
    idle(45);

    // pool full, then a hit frees slot 2 for the pending tank 1 press
    for (int k = 0; k <= 35; k++) begin
      case (k)
        0, 17, 20: fire_req = 2'b10;
        1, 18:     fire_req = 2'b01;
        default:   fire_req = 2'b00;
      endcase
      hit_clear = (k == 34) ? 4'b0100 : 4'b0000;
      step();
      chk("pool_valid", spawn_valid, (k == 0 || k == 1 || k == 17 || k == 18 || k == 35) ? 1 : 0);
      if (k == 19) chk("pool_full", slot_active, 4'b1111);
      if (k == 34) chk("pool_hit", slot_active, 4'b1011);
      if (k == 35) begin
        chk("pool_slot", spawn_slot, 2);
        chk("pool_owner", spawn_owner, 1);
      end
    end
    hit_clear = 4'b0001;
    step();
    hit_clear = '0;

    // reset mid-flight with both keys held
    fire_req = 2'b11;
    Reset    = 1'b0;
    step();
    chk("mid_rst_active", slot_active, 0);
    chk("mid_rst_valid", spawn_valid, 0);
    chk("mid_rst_slot", spawn_slot, 0);
    chk("mid_rst_angle", spawn_angle, 0);
    Reset  = 1'b1;
    spawns = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (spawn_valid) spawns++;
    end
    chk("held_after_rst", spawns, 0);
    fire_req = 2'b00;
    step();
    fire_req = 2'b11;
    step();
    chk("repress_valid", spawn_valid, 1);
    chk("repress_owner", spawn_owner, 0);
    step();
    chk("repress2_owner", spawn_owner, 1);
    chk("repress2_slot", spawn_slot, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
